axis_overdrive: RTL and testbench

- AXI-Stream audio effect stage directly downstream of the I2S2 receiver and upstream of the I2S2 transmitter.
- Consumes 2-word stereo packets (left then right, 24-bit signed samples in bits [23:0] of 32-bit words), applies gain, saturation and soft-knee clipping (overdrive), and emits a 2-word packet in the same format.
- Holds one packet in flight; no FIFO.

---
 rtl/axis_overdrive_if.sv | 24 ++
 rtl/axis_overdrive.sv | 209 ++++++++++++++++++++
 tb/tb_axis_overdrive.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_overdrive_if.sv
// Stream bundle between the effect stage and its neighbours: one 32-bit
// audio word per beat, with last marking the right-channel word.
interface axis_overdrive_if #(
  parameter int W = 32
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/axis_overdrive.sv
// Stereo overdrive stage: collects an L/R pair, applies Q-format gain,
// saturates to the sample range, soft-clips above a knee (the excess is
// halved), and sends the pair on. Exactly one packet is in flight, so the
// input and output sides are never active at the same time.
module axis_overdrive #(
  parameter int DATA_W    = 24,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic                axis_clk,
  input  logic                axis_resetn,
  axis_overdrive_if.slave     s_axis,
  axis_overdrive_if.master    m_axis,
  input  logic [GAIN_W-1:0]   gain,
  input  logic [DATA_W-2:0]   threshold,
  input  logic                bypass,
  output logic [7:0]          err_count
);

  // Product width: sign-extended sample times zero-extended gain, no overflow.
  localparam int PROD_W = DATA_W + GAIN_W + 1;

  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(GAIN_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(GAIN_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    RX_L = 3'd0,
    RX_R = 3'd1,
    C1   = 3'd2,
    C2   = 3'd3,
    C3   = 3'd4,
    TX_L = 3'd5,
    TX_R = 3'd6
  } state_t;

  state_t state, state_nx;

  logic rx_en;
  logic s_ready_c;
  logic m_valid_c;
  logic m_last_c;
  logic [31:0] m_data_c;
  logic s_fire;
  logic malformed;

  logic signed [DATA_W-1:0] x_l, x_r;
  logic        [GAIN_W-1:0] gain_q;
  logic        [DATA_W-2:0] thr_q;
  logic                     byp_q;

  logic signed [PROD_W-1:0] x_l_ext, x_r_ext, gain_ext;
  logic signed [PROD_W-1:0] prod_l_p0, prod_r_p0;
  logic signed [DATA_W-1:0] sat_l_p1, sat_r_p1;
  logic signed [DATA_W-1:0] y_l_p2, y_r_p2;

  // Upper byte of the input word carries nothing for this stage.
  logic unused_data_hi;
  assign unused_data_hi = ^s_axis.data[31:DATA_W];

  // Clamp a scaled value into the signed sample range.
  function automatic logic signed [DATA_W-1:0] sat_sample(
    input logic signed [PROD_W-1:0] v
  );
    logic signed [DATA_W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
    else                  r = v[DATA_W-1:0];
    return r;
  endfunction

  // Soft knee on the magnitude; the most negative code folds onto the
  // positive maximum so the magnitude always fits DATA_W-1 bits.
  function automatic logic signed [DATA_W-1:0] soft_clip(
    input logic signed [DATA_W-1:0] q,
    input logic        [DATA_W-2:0] thr
  );
    logic signed [DATA_W-1:0] nq;
    logic signed [DATA_W-1:0] mag_s;
    logic        [DATA_W-2:0] a;
    logic        [DATA_W-2:0] m;
    nq = -q;
    if (q[DATA_W-1] && (q[DATA_W-2:0] == '0)) a = '1;
    else if (q[DATA_W-1])                      a = nq[DATA_W-2:0];
    else                                       a = q[DATA_W-2:0];
    if (a <= thr) m = a;
    else          m = thr + ((a - thr) >> 1);
    mag_s = {1'b0, m};
    return q[DATA_W-1] ? -mag_s : mag_s;
  endfunction

  assign s_fire    = s_ready_c && s_axis.valid;
  assign malformed = s_fire && (((state == RX_L) && s_axis.last) ||
                                ((state == RX_R) && !s_axis.last));

  assign x_l_ext  = $signed({{(GAIN_W + 1){x_l[DATA_W-1]}}, x_l});
  assign x_r_ext  = $signed({{(GAIN_W + 1){x_r[DATA_W-1]}}, x_r});
  assign gain_ext = $signed({{(DATA_W + 1){1'b0}}, gain_q});

  // State register.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) state <= RX_L;
    else              state <= state_nx;
  end

  // Holds the input closed until the first clock after reset release.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) rx_en <= 1'b0;
    else              rx_en <= 1'b1;
  end

  // Next-state: collect L then R, three compute cycles, then emit L then R.
  always_comb begin
    state_nx = state;
    case (state)
      RX_L:    if (s_fire && !s_axis.last) state_nx = RX_R;
      RX_R:    if (s_fire && s_axis.last)  state_nx = C1;
      C1:      state_nx = C2;
      C2:      state_nx = C3;
      C3:      state_nx = TX_L;
      TX_L:    if (m_axis.ready) state_nx = TX_R;
      TX_R:    if (m_axis.ready) state_nx = RX_L;
      default: state_nx = RX_L;
    endcase
  end

  // Handshake outputs decoded from state; data held in the result registers.
  always_comb begin
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    m_last_c  = 1'b0;
    m_data_c  = '0;
    case (state)
      RX_L, RX_R: s_ready_c = rx_en;
      TX_L: begin
        m_valid_c = 1'b1;
        m_data_c  = {{(32 - DATA_W){1'b0}}, y_l_p2};
      end
      TX_R: begin
        m_valid_c = 1'b1;
        m_last_c  = 1'b1;
        m_data_c  = {{(32 - DATA_W){1'b0}}, y_r_p2};
      end
      default: ;
    endcase
  end

  assign s_axis.ready = s_ready_c;
  assign m_axis.valid = m_valid_c;
  assign m_axis.last  = m_last_c;
  assign m_axis.data  = m_data_c;

  // Malformed-packet counter, sticking at its maximum.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn)                          err_count <= 8'd0;
    else if (malformed && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
  end

  // Sample capture and the three compute stages, each advanced by its state.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      x_l       <= '0;
      x_r       <= '0;
      gain_q    <= '0;
      thr_q     <= '0;
      byp_q     <= 1'b0;
      prod_l_p0 <= '0;
      prod_r_p0 <= '0;
      sat_l_p1  <= '0;
      sat_r_p1  <= '0;
      y_l_p2    <= '0;
      y_r_p2    <= '0;
    end else begin
      case (state)
        RX_L: begin
          if (s_fire && !s_axis.last) x_l <= s_axis.data[DATA_W-1:0];
        end
        RX_R: begin
          // A repeated non-last word restarts the packet with a new left sample.
          if (s_fire && !s_axis.last) x_l <= s_axis.data[DATA_W-1:0];
          if (s_fire && s_axis.last) begin
            x_r    <= s_axis.data[DATA_W-1:0];
            gain_q <= gain;
            thr_q  <= threshold;
            byp_q  <= bypass;
          end
        end
        // Stage p0: full-width gain product.
        C1: begin
          prod_l_p0 <= x_l_ext * gain_ext;
          prod_r_p0 <= x_r_ext * gain_ext;
        end
        // Stage p1: drop fractional gain bits (floor) and saturate.
        C2: begin
          sat_l_p1 <= sat_sample(prod_l_p0 >>> GAIN_FRAC);
          sat_r_p1 <= sat_sample(prod_r_p0 >>> GAIN_FRAC);
        end
        // Stage p2: soft knee, or the untouched input when bypassed.
        C3: begin
          y_l_p2 <= byp_q ? x_l : soft_clip(sat_l_p1, thr_q);
          y_r_p2 <= byp_q ? x_r : soft_clip(sat_r_p1, thr_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_overdrive.sv
// Bench for axis_overdrive: fixed vector table, hand-written corner
// sequences and randomized packets against an arithmetic reference.
module tb_axis_overdrive;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gain;
  logic [22:0] thr;
  logic        byp;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  axis_overdrive_if s_if ();
  axis_overdrive_if m_if ();

  axis_overdrive dut (
    .axis_clk   (clk),
    .axis_resetn(rst_n),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .gain       (gain),
    .threshold  (thr),
    .bypass     (byp),
    .err_count  (err_count)
  );

  typedef struct {
    logic [7:0]  g;
    logic [22:0] t;
    logic        b;
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  vec_t vecs [8];
  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word; returns just after the edge that accepted it.
  task automatic put(input logic [23:0] d, input logic last);
    int n = 0;
    s_if.data  = {8'hA5, d};
    s_if.last  = last;
    s_if.valid = 1'b1;
    while (s_if.ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (s_if.ready !== 1'b1) check("put_ready_timeout", 32'(s_if.ready), 32'd1);
    tick();
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [23:0] l, input logic [23:0] r);
    put(l, 1'b0);
    put(r, 1'b1);
  endtask

  // Wait for an output word, compare it, then take it.
  task automatic get(input string nm, input logic [31:0] exp_d, input logic exp_last);
    int n = 0;
    m_if.ready = 1'b1;
    while (m_if.valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({nm, "_valid"}, 32'(m_if.valid), 32'd1);
    check({nm, "_data"}, m_if.data, exp_d);
    check({nm, "_last"}, 32'(m_if.last), 32'(exp_last));
    tick();
  endtask

  // Reference: gain as a rational, floor division, clamp, halved excess.
  function automatic logic [31:0] model(input logic [23:0] x, input logic [7:0] g,
                                        input logic [22:0] t, input logic b);
    longint xs, p, q, a, y, tl;
    logic [63:0] yb;
    if (b) return {8'h00, x};
    xs = longint'($signed(x));
    p  = xs * longint'(g);
    if (p < 0) q = -((-p + 15) / 16);
    else       q = p / 16;
    if (q > 8388607)  q = 8388607;
    if (q < -8388608) q = -8388608;
    a = (q < 0) ? -q : q;
    if (a > 8388607) a = 8388607;
    tl = longint'(t);
    y = (a <= tl) ? a : tl + (a - tl) / 2;
    if (q < 0) y = -y;
    yb = y;
    return {8'h00, yb[23:0]};
  endfunction

  initial begin
    logic [31:0] cap;
    int bad;
    logic [23:0] rl, rr;

    vecs[0] = '{8'd32,  23'h200000, 1'b0, 24'h400000, 24'h000800, 32'h004FFFFF, 32'h00001000};
    vecs[1] = '{8'd16,  23'h080000, 1'b0, 24'hF00000, 24'h000000, 32'h00F40000, 32'h00000000};
    vecs[2] = '{8'd16,  23'h7FFFFF, 1'b0, 24'h800000, 24'h7FFFFF, 32'h00800001, 32'h007FFFFF};
    vecs[3] = '{8'd255, 23'h000010, 1'b1, 24'h123456, 24'hABCDEF, 32'h00123456, 32'h00ABCDEF};
    vecs[4] = '{8'd8,   23'h7FFFFF, 1'b0, 24'hFFFFFF, 24'h000001, 32'h00FFFFFF, 32'h00000000};
    vecs[5] = '{8'd0,   23'h000000, 1'b0, 24'h7FFFFF, 24'h800000, 32'h00000000, 32'h00000000};
    vecs[6] = '{8'd16,  23'h000000, 1'b0, 24'h000100, 24'hFFFF00, 32'h00000080, 32'h00FFFF80};
    vecs[7] = '{8'd255, 23'h7FFFFF, 1'b0, 24'h000100, 24'hFFFFFF, 32'h00000FF0, 32'h00FFFFF0};

    s_if.data  = '0;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    gain = 8'd16;
    thr  = 23'h7FFFFF;
    byp  = 1'b0;

    // Reset state.
    #22;
    check("rst_s_ready", 32'(s_if.ready), 32'd0);
    check("rst_m_valid", 32'(m_if.valid), 32'd0);
    check("rst_m_last",  32'(m_if.last),  32'd0);
    check("rst_m_data",  m_if.data, 32'd0);
    check("rst_err",     32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_s_ready_pre", 32'(s_if.ready), 32'd0);
    tick();
    check("rel_s_ready_post", 32'(s_if.ready), 32'd1);

    // Unity path with latency.
    send_pkt(24'h000100, 24'hFFFF00);
    check("lat_c1_ready", 32'(s_if.ready), 32'd0);
    check("lat_c1_valid", 32'(m_if.valid), 32'd0);
    tick();
    check("lat_c2_valid", 32'(m_if.valid), 32'd0);
    tick();
    check("lat_c3_valid", 32'(m_if.valid), 32'd0);
    tick();
    check("lat_txl_valid", 32'(m_if.valid), 32'd1);
    check("lat_txl_ready", 32'(s_if.ready), 32'd0);
    get("unity_l", 32'h00000100, 1'b0);
    get("unity_r", 32'h00FFFF00, 1'b1);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      gain = vecs[i].g;
      thr  = vecs[i].t;
      byp  = vecs[i].b;
      send_pkt(vecs[i].l, vecs[i].r);
      get($sformatf("vec%0d_l", i), vecs[i].el, 1'b0);
      get($sformatf("vec%0d_r", i), vecs[i].er, 1'b1);
    end

    // Settings changed during C2 must not touch the packet in flight.
    gain = 8'd32;
    thr  = 23'h7FFFFF;
    byp  = 1'b0;
    send_pkt(24'h000100, 24'h000300);
    tick();
    byp  = 1'b1;
    gain = 8'd255;
    thr  = 23'h0;
    get("midpkt_l", 32'h00000200, 1'b0);
    get("midpkt_r", 32'h00000600, 1'b1);
    gain = 8'd16;
    thr  = 23'h7FFFFF;
    byp  = 1'b0;

    // Backpressure in TX_L.
    m_if.ready = 1'b0;
    send_pkt(24'h345678, 24'h000001);
    tick();
    tick();
    tick();
    check("bp_valid", 32'(m_if.valid), 32'd1);
    cap = m_if.data;
    bad = 0;
    repeat (20) begin
      tick();
      if (m_if.data !== cap || m_if.last !== 1'b0 || s_if.ready !== 1'b0 ||
          m_if.valid !== 1'b1) bad++;
    end
    check("bp_stable_cycles_bad", 32'(bad), 32'd0);
    check("bp_data", cap, 32'h00345678);
    get("bp_l", 32'h00345678, 1'b0);
    get("bp_r", 32'h00000001, 1'b1);

    // Malformed words.
    put(24'h111111, 1'b1);
    check("mal_rxl_err", 32'(err_count), 32'd1);
    send_pkt(24'h000010, 24'h000020);
    get("mal_next_l", 32'h00000010, 1'b0);
    get("mal_next_r", 32'h00000020, 1'b1);
    put(24'h000030, 1'b0);
    put(24'h000040, 1'b0);
    check("mal_rxr_err", 32'(err_count), 32'd2);
    put(24'h000050, 1'b1);
    get("mal_rxr_l", 32'h00000040, 1'b0);
    get("mal_rxr_r", 32'h00000050, 1'b1);
    for (int i = 0; i < 300; i++) put(24'(i), 1'b1);
    check("mal_err_sat", 32'(err_count), 32'd255);
    send_pkt(24'h000777, 24'h000888);
    get("mal_after_l", 32'h00000777, 1'b0);
    get("mal_after_r", 32'h00000888, 1'b1);

    // Reset while the right word is on the output.
    send_pkt(24'h0ABCDE, 24'h012345);
    get("rst_tx_l", 32'h000ABCDE, 1'b0);
    m_if.ready = 1'b0;
    check("rst_txr_last", 32'(m_if.last), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(m_if.valid), 32'd0);
    check("rst_async_last",  32'(m_if.last),  32'd0);
    check("rst_async_data",  m_if.data, 32'd0);
    check("rst_async_err",   32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_rel_ready", 32'(s_if.ready), 32'd1);
    send_pkt(24'h000100, 24'hF00000);
    get("rst_after_l", 32'h00000100, 1'b0);
    get("rst_after_r", 32'h00F00000, 1'b1);

    // Randomized packets against the reference.
    for (int i = 0; i < 40; i++) begin
      gain = 8'($urandom);
      thr  = 23'($urandom);
      byp  = ($urandom_range(0, 3) == 0);
      rl   = 24'($urandom);
      rr   = 24'($urandom);
      if (i < 4) rl = (i[0]) ? 24'h800000 : 24'h7FFFFF;
      m_if.ready = 1'b0;
      send_pkt(rl, rr);
      repeat ($urandom_range(0, 4)) tick();
      get($sformatf("rnd%0d_l", i), model(rl, gain, thr, byp), 1'b0);
      get($sformatf("rnd%0d_r", i), model(rr, gain, thr, byp), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
